// File: rtl/md_unit_if.sv
// Handshake and result bundle between the execute-stage controller and md_unit.
interface md_unit_if #(
    parameter int WIDTH = 32
) ();
    logic [3:0]       op;
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output op, start, flush, a, b, input busy, done, hi, lo);
    modport slave  (input op, start, flush, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; results are computed at launch,
// held as pending, and committed after a fixed busy period.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    md_unit_if.slave     md
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);
    localparam logic [1:0] M_SET = 2'd0, M_ADD = 2'd1, M_SUB = 2'd2, M_KEEP = 2'd3;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]  r_pend;
    logic [1:0]          r_mode;
    logic                r_busy, r_done;
    logic [WIDTH-1:0]    r_hi, r_lo;

    logic                w_is_mul, w_is_div, w_signed, w_idle, w_go, w_last, w_div_zero;
    logic [1:0]          w_mode;
    logic [2*WIDTH-1:0]  w_ext_a, w_ext_b, w_prod;
    logic [WIDTH-1:0]    w_abs_a, w_abs_b, w_div_b, w_uq, w_ur, w_quo, w_rem;

    // Opcode decode into operation class, signedness and HI/LO commit mode
    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        w_signed = 1'b0;
        w_mode   = M_SET;
        case (md.op)
            4'd1:    w_is_mul = 1'b1;
            4'd2:    w_is_div = 1'b1;
            4'd3:    begin w_is_mul = 1'b1; w_signed = 1'b1; end
            4'd4:    begin w_is_div = 1'b1; w_signed = 1'b1; end
            4'd7:    begin w_is_mul = 1'b1; w_signed = 1'b1; w_mode = M_ADD; end
            4'd8:    begin w_is_mul = 1'b1; w_mode = M_ADD; end
            4'd9:    begin w_is_mul = 1'b1; w_signed = 1'b1; w_mode = M_SUB; end
            4'd10:   begin w_is_mul = 1'b1; w_mode = M_SUB; end
            default: w_is_mul = 1'b0;
        endcase
    end

    assign w_idle  = (r_state == S_IDLE);
    assign w_go    = md.start && !md.flush && w_idle;

    // Sign/zero-extending to 2*WIDTH makes one truncated multiply serve both kinds
    assign w_ext_a = w_signed ? {{WIDTH{md.a[WIDTH-1]}}, md.a} : {{WIDTH{1'b0}}, md.a};
    assign w_ext_b = w_signed ? {{WIDTH{md.b[WIDTH-1]}}, md.b} : {{WIDTH{1'b0}}, md.b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed divide via magnitudes; MIN/-1 naturally yields MIN with zero remainder
    assign w_abs_a    = (w_signed && md.a[WIDTH-1]) ? (~md.a + WIDTH'(1)) : md.a;
    assign w_abs_b    = (w_signed && md.b[WIDTH-1]) ? (~md.b + WIDTH'(1)) : md.b;
    assign w_div_zero = (md.b == {WIDTH{1'b0}});
    assign w_div_b    = w_div_zero ? WIDTH'(1) : w_abs_b;
    assign w_uq       = w_abs_a / w_div_b;
    assign w_ur       = w_abs_a % w_div_b;
    assign w_quo      = (w_signed && (md.a[WIDTH-1] ^ md.b[WIDTH-1])) ? (~w_uq + WIDTH'(1)) : w_uq;
    assign w_rem      = (w_signed && md.a[WIDTH-1]) ? (~w_ur + WIDTH'(1)) : w_ur;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state and end-of-latency detection
    always_comb begin
        w_state_nxt = r_state;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go && w_is_mul)      w_state_nxt = S_MUL;
                else if (w_go && w_is_div) w_state_nxt = S_DIV;
                else                       w_state_nxt = S_IDLE;
            end
            S_MUL: begin
                w_last      = (r_cnt == MUL_LAST);
                w_state_nxt = w_last ? S_IDLE : S_MUL;
            end
            S_DIV: begin
                w_last      = (r_cnt == DIV_LAST);
                w_state_nxt = w_last ? S_IDLE : S_DIV;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latency counter, pending result capture, HI/LO commit and moves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= {CW{1'b0}};
            r_pend <= {(2*WIDTH){1'b0}};
            r_mode <= M_SET;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_hi   <= {WIDTH{1'b0}};
            r_lo   <= {WIDTH{1'b0}};
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_last;
            if (w_idle || w_last) r_cnt <= {CW{1'b0}};
            else                  r_cnt <= r_cnt + CW'(1);

            if (w_go && w_is_mul) begin
                r_pend <= w_prod;
                r_mode <= w_mode;
            end else if (w_go && w_is_div) begin
                r_pend <= {w_rem, w_quo};
                r_mode <= w_div_zero ? M_KEEP : M_SET;
            end else begin
                r_pend <= r_pend;
                r_mode <= r_mode;
            end

            // Accumulating modes read HI/LO at commit so earlier moves are included
            if (w_last) begin
                case (r_mode)
                    M_SET:   {r_hi, r_lo} <= r_pend;
                    M_ADD:   {r_hi, r_lo} <= {r_hi, r_lo} + r_pend;
                    M_SUB:   {r_hi, r_lo} <= {r_hi, r_lo} - r_pend;
                    default: {r_hi, r_lo} <= {r_hi, r_lo};
                endcase
            end else if (w_idle && !md.flush && md.op == 4'd5) begin
                r_hi <= md.a;
            end else if (w_idle && !md.flush && md.op == 4'd6) begin
                r_lo <= md.a;
            end else begin
                r_hi <= r_hi;
                r_lo <= r_lo;
            end
        end
    end

    assign md.busy = r_busy;
    assign md.done = r_done;
    assign md.hi   = r_hi;
    assign md.lo   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// Directed and randomized bench for md_unit against an arithmetic reference of HI/LO.
module tb_md_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_if #(.WIDTH(32)) md ();
    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .md(md)
    );

    int checks = 0;
    int failures = 0;
    logic [63:0] m_acc;   // reference {hi,lo}

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result for a completed operation, from the arithmetic definitions
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        int ia, ib, q, r;
        longint sa, sb, sp;
        logic [63:0] up;
        ia = a; ib = b; sa = ia; sb = ib;
        sp = sa * sb;
        up = {32'd0, a} * {32'd0, b};
        case (op)
            4'd1:  return up;
            4'd3:  return sp;
            4'd7:  return acc + sp;
            4'd8:  return acc + up;
            4'd9:  return acc - sp;
            4'd10: return acc - up;
            4'd2:  if (b == 32'd0) return acc; else return {a % b, a / b};
            4'd4: begin
                if (b == 32'd0) return acc;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = ia / ib; r = ia % ib;
                return {r, q};
            end
            default: return acc;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit flush_mid, input bit start_mid, input string tag);
        int n, busy_cnt, last_busy, done_cnt, done_idx;
        logic [63:0] exp;
        n = (op == 4'd2 || op == 4'd4) ? 10 : 5;
        busy_cnt = 0; last_busy = -1; done_cnt = 0; done_idx = -1;
        exp = model(op, a, b, m_acc);
        @(negedge clk);
        md.op = op; md.start = 1'b1; md.a = a; md.b = b;
        @(negedge clk);
        md.op = 4'd0; md.start = 1'b0; md.a = $urandom; md.b = $urandom;
        for (int i = 0; i < n + 4; i++) begin
            if (md.busy) begin busy_cnt++; last_busy = i; end
            if (md.done) begin done_cnt++; done_idx = i; end
            md.flush = (flush_mid && i == 2);
            if (start_mid && i == 3) begin md.op = 4'd1; md.start = 1'b1; end
            else begin md.op = 4'd0; md.start = 1'b0; end
            @(negedge clk);
        end
        m_acc = exp;
        check({tag, "_busy_len"}, 64'(busy_cnt), 64'(n));
        check({tag, "_busy_end"}, 64'(last_busy), 64'(n - 1));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_done_at"}, 64'(done_idx), 64'(n));
        check({tag, "_hilo"}, {md.hi, md.lo}, m_acc);
    endtask

    task automatic move(input logic [3:0] op, input logic [31:0] a, input bit fl, input string tag);
        @(negedge clk);
        md.op = op; md.a = a; md.flush = fl;
        @(negedge clk);
        md.op = 4'd0; md.flush = 1'b0; md.a = $urandom;
        if (!fl && op == 4'd5) m_acc[63:32] = a;
        if (!fl && op == 4'd6) m_acc[31:0] = a;
        check({tag, "_hilo"}, {md.hi, md.lo}, m_acc);
    endtask

    initial begin
        logic [3:0]  ops [10];
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        int busy_seen, done_seen;
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
        md.op = 4'd0; md.start = 1'b0; md.flush = 1'b0; md.a = 32'd0; md.b = 32'd0;
        reset = 1'b1;
        #12;
        check("reset_busy", 64'(md.busy), 64'd0);
        check("reset_done", 64'(md.done), 64'd0);
        check("reset_hilo", {md.hi, md.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_acc = 64'd0;

        run_op(4'd3, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, "mult");
        check("mult_const", {md.hi, md.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div");
        check("div_const", {md.hi, md.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd2, 32'd7, 32'd0, 1'b0, 1'b0, "divu_zero");
        check("divu_zero_const", {md.hi, md.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        move(4'd5, 32'd0, 1'b0, "mthi");
        move(4'd6, 32'd10, 1'b0, "mtlo");
        run_op(4'd8, 32'd3, 32'd4, 1'b0, 1'b0, "maddu");
        check("maddu_const", {md.hi, md.lo}, 64'd22);
        run_op(4'd9, 32'd1, 32'd23, 1'b0, 1'b0, "msub");
        check("msub_const", {md.hi, md.lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, "div_min");
        check("div_min_const", {md.hi, md.lo}, 64'h0000_0000_8000_0000);

        // Launch under flush must not start anything
        @(negedge clk);
        md.op = 4'd3; md.start = 1'b1; md.flush = 1'b1; md.a = 32'd9; md.b = 32'd9;
        @(negedge clk);
        md.op = 4'd0; md.start = 1'b0; md.flush = 1'b0;
        busy_seen = 0; done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (md.busy) busy_seen++;
            if (md.done) done_seen++;
            @(negedge clk);
        end
        check("flush_start_busy", 64'(busy_seen), 64'd0);
        check("flush_start_done", 64'(done_seen), 64'd0);
        check("flush_start_hilo", {md.hi, md.lo}, m_acc);
        move(4'd6, 32'h1234_5678, 1'b1, "mtlo_flush");
        run_op(4'd1, $urandom, $urandom, 1'b1, 1'b0, "multu_flush_mid");

        for (int k = 0; k < 24; k++) begin
            rop = ops[$urandom_range(0, 9)];
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            if (rop == 4'd5 || rop == 4'd6) move(rop, ra, 1'b0, "rnd_move");
            else run_op(rop, ra, rb, 1'b0, 1'b0, "rnd_op");
        end

        // Reset in the middle of a multiply
        @(negedge clk);
        md.op = 4'd3; md.start = 1'b1; md.a = 32'd1234; md.b = 32'd5678;
        @(negedge clk);
        md.op = 4'd0; md.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        m_acc = 64'd0;
        check("rst_mid_busy", 64'(md.busy), 64'd0);
        check("rst_mid_done", 64'(md.done), 64'd0);
        check("rst_mid_hilo", {md.hi, md.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        busy_seen = 0; done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (md.busy) busy_seen++;
            if (md.done) done_seen++;
            @(negedge clk);
        end
        check("rst_after_busy", 64'(busy_seen), 64'd0);
        check("rst_after_done", 64'(done_seen), 64'd0);
        check("rst_after_hilo", {md.hi, md.lo}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
